add_seq: RTL and testbench

Multi-precision add sequencer: accepts two WORDS×16-bit operands plus carry-in and produces the WORDS×16-bit sum and carry-out. It reuses a single `add16` instance over WORDS cycles, processing the least significant slice first and registering the carry between slices. The block sits between a requester with a valid/ready stream and the shared 16-bit adder datapath, trading latency for area.

---
 rtl/add_seq_pkg.sv | 18 +
 rtl/add_seq_if.sv | 28 ++
 rtl/add_seq_add16.sv | 13 +
 rtl/add_seq.sv | 101 ++++++++++
 tb/tb_add_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the multi-precision add sequencer.
// Holds the FSM state encoding, the slice width and the idx-width helper.
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // idx needs at least one bit even when there is only a single slice
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_seq_if.sv
// Request/response stream bundle between a requester and add_seq.
// The master side is the requester; add_seq connects to the slave side.
interface add_seq_if import add_seq_pkg::*; #(
  parameter int WORDS = 4
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [SLICE_W*WORDS-1:0]   a;
  logic [SLICE_W*WORDS-1:0]   b;
  logic                       cin;
  logic                       out_valid;
  logic                       out_ready;
  logic [SLICE_W*WORDS-1:0]   sum;
  logic                       cout;
  logic                       busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/add_seq_add16.sv
// Shared 16-bit adder datapath reused by add_seq for every slice.
// Purely combinational; carry-in and carry-out ripple through the sequencer.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/add_seq.sv
// Multi-precision add sequencer: one add16 walked over WORDS slices, LS first,
// with the carry held in a register between slices.
//
// state | meaning
// IDLE  | ready for a request; sum/cout keep the last result
// RUN   | adding slice idx, one slice per cycle
// DONE  | result valid, held until out_ready
module add_seq import add_seq_pkg::*; #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  add_seq_if.slave    bus
);

  localparam int IW = idx_w(WORDS);
  localparam int DW = SLICE_W * WORDS;

  state_t               state_q, state_d;
  logic [DW-1:0]        a_q, b_q, sum_q;
  logic                 carry_q, cout_q;
  logic [IW-1:0]        idx_q;
  logic [SLICE_W-1:0]   a_sl, b_sl, s_sl;
  logic                 c_sl;
  logic                 last;

  assign last = (idx_q == IW'(WORDS - 1));

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  add16 u_add16 (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) sum_q[i*SLICE_W +: SLICE_W] <= s_sl;
          end
          carry_q <= c_sl;
          // idx parks on the last slice so a single-slice build never wraps
          if (last) cout_q <= c_sl;
          else      idx_q  <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed cases on a 4-slice build, then a
// random soak on both the 4-slice and 1-slice builds against a wide-add model.
module tb_add_seq;
  import add_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic        in_valid, cin, out_ready;
  logic [63:0] a_v, b_v;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  add_seq_if #(.WORDS(4)) if4 ();
  add_seq_if #(.WORDS(1)) if1 ();

  add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  add_seq #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if4.in_valid  = in_valid && (sel == 4);
  assign if4.out_ready = out_ready && (sel == 4);
  assign if4.a         = a_v;
  assign if4.b         = b_v;
  assign if4.cin       = cin;
  assign if1.in_valid  = in_valid && (sel == 1);
  assign if1.out_ready = out_ready && (sel == 1);
  assign if1.a         = a_v[15:0];
  assign if1.b         = b_v[15:0];
  assign if1.cin       = cin;

  logic        ov, ir, bz, co;
  logic [63:0] sum_o;
  assign ov    = (sel == 1) ? if1.out_valid : if4.out_valid;
  assign ir    = (sel == 1) ? if1.in_ready  : if4.in_ready;
  assign bz    = (sel == 1) ? if1.busy      : if4.busy;
  assign co    = (sel == 1) ? if1.cout      : if4.cout;
  assign sum_o = (sel == 1) ? {48'd0, if1.sum} : if4.sum;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide addition of the operands truncated to w slices
  function automatic logic [64:0] ref_add(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c);
    logic [64:0] m;
    m = (w == 4) ? 65'h0_FFFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_0000_FFFF;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {64'd0, c};
  endfunction

  // Issue one request from a negedge with the selected DUT idle; returns at a
  // negedge after the handoff, DUT back in IDLE.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input int stall, input logic pre, input string tag);
    logic [64:0] full;
    logic [63:0] es;
    logic        ec;
    int          lat;
    full = ref_add(w, a, b, c);
    es   = (w == 4) ? full[63:0] : {48'd0, full[15:0]};
    ec   = full[16*w];
    sel = w; a_v = a; b_v = b; cin = c; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk({tag, " in_ready idle"}, ir, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = pre;
    chk({tag, " busy run"}, bz, 1);
    chk({tag, " in_ready run"}, ir, 0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ov && lat < 50);
    chk({tag, " latency"}, lat, w);
    chk({tag, " sum"}, sum_o, es);
    chk({tag, " cout"}, co, ec);
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " held sum"}, sum_o, es);
      chk({tag, " held out_valid"}, ov, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " in_ready after"}, ir, 1);
    chk({tag, " out_valid after"}, ov, 0);
    chk({tag, " sum retained"}, sum_o, es);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rc, pre;
    int          st;

    rst_n = 1'b0; sel = 4; in_valid = 1'b0; out_ready = 1'b0;
    cin = 1'b0; a_v = '0; b_v = '0;
    repeat (2) @(negedge clk);
    chk("rst in_ready4", if4.in_ready, 1);
    chk("rst out_valid4", if4.out_valid, 0);
    chk("rst busy4", if4.busy, 0);
    chk("rst sum4", if4.sum, 0);
    chk("rst cout4", if4.cout, 0);
    chk("rst in_ready1", if1.in_ready, 1);
    chk("rst sum1", if1.sum, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4, 64'h1, 64'h2, 1'b0, 0, 1'b0, "simple");
    run_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 1'b0, "ripple");
    run_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b1, "max");

    // Backpressure: result must hold while new requests are ignored
    sel = 4; a_v = 64'h8000_0000_0000_0001; b_v = 64'h8000_0000_0000_0002; cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp out_valid", ov, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      a_v = {$urandom, $urandom};
      b_v = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      chk("bp sum", sum_o, 64'h0000_0000_0000_0004);
      chk("bp cout", co, 1);
      chk("bp out_valid hold", ov, 1);
      chk("bp in_ready", ir, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle in_ready", ir, 1);
    chk("bp idle out_valid", ov, 0);

    // Reset two cycles into RUN clears everything asynchronously
    a_v = 64'h1234_5678_9ABC_DEF0; b_v = 64'h1111_2222_3333_4444; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", ov, 0);
    chk("midrst sum", sum_o, 0);
    chk("midrst cout", co, 0);
    chk("midrst busy", bz, 0);
    chk("midrst in_ready", ir, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4, 64'h1, 64'h1, 1'b0, 0, 1'b0, "post rst");

    for (int w = 4; w >= 1; w -= 3) begin
      for (int n = 0; n < 1000; n++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) ra = ~rb;
        st  = $urandom_range(0, 3);
        pre = (st == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        run_op(w, ra, rb, rc, st, pre, (w == 4) ? "soak4" : "soak1");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
